// File: rtl/pio_in_edge_irq.sv
// Avalon-MM input PIO: synchronized, optionally debounced pins with sticky
// edge capture and a masked, registered level interrupt.
module pio_in_edge_irq #(
  parameter int unsigned WIDTH           = 4,
  parameter int unsigned EDGE_TYPE       = 0,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync_val;
  logic [WIDTH-1:0] stable_q;
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] rise, fall, evt;
  logic [WIDTH-1:0] irq_mask_q, irq_mask_d;
  logic [WIDTH-1:0] edge_capture_q, edge_capture_d;
  logic [WIDTH-1:0] clr_bits;
  logic             wr_en;
  logic             irq_q;
  logic             unused_wdata;

  // Upper write-data bits above WIDTH are intentionally ignored.
  assign unused_wdata = ^writedata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= '0;
      end
    end else begin
      sync_q[0] <= in_port;
      for (int unsigned s = 1; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
    end
  end

  assign sync_val = sync_q[SYNC_STAGES-1];

  if (DEBOUNCE_CYCLES == 0) begin : g_no_debounce
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        stable_q <= '0;
      end else begin
        stable_q <= sync_val;
      end
    end
  end else begin : g_debounce
    localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

    logic [CntW-1:0] cnt_q [WIDTH];

    // A bit only follows sync_val after DEBOUNCE_CYCLES consecutive mismatching cycles.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        stable_q <= '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
          cnt_q[i] <= '0;
        end
      end else begin
        for (int unsigned i = 0; i < WIDTH; i++) begin
          if (sync_val[i] == stable_q[i]) begin
            cnt_q[i] <= '0;
          end else if (cnt_q[i] == CntLast) begin
            stable_q[i] <= sync_val[i];
            cnt_q[i]    <= '0;
          end else begin
            cnt_q[i] <= cnt_q[i] + 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    rise = stable_q & ~prev_q;
    fall = ~stable_q & prev_q;
    if (EDGE_TYPE == 0) begin
      evt = rise;
    end else if (EDGE_TYPE == 1) begin
      evt = fall;
    end else begin
      evt = rise | fall;
    end
  end

  assign wr_en = chipselect && !write_n;

  always_comb begin
    clr_bits   = '0;
    irq_mask_d = irq_mask_q;
    if (wr_en && (address == 2'd3)) begin
      clr_bits = writedata[WIDTH-1:0];
    end
    if (wr_en && (address == 2'd2)) begin
      irq_mask_d = writedata[WIDTH-1:0];
    end
    // A new event on a bit wins over a same-cycle clear of that bit.
    edge_capture_d = (edge_capture_q & ~clr_bits) | evt;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_q         <= '0;
      irq_mask_q     <= '0;
      edge_capture_q <= '0;
      irq_q          <= 1'b0;
    end else begin
      prev_q         <= stable_q;
      irq_mask_q     <= irq_mask_d;
      edge_capture_q <= edge_capture_d;
      irq_q          <= |(edge_capture_q & irq_mask_q);
    end
  end

  assign irq = irq_q;

  always_comb begin
    readdata = '0;
    if (chipselect) begin
      unique case (address)
        2'd0: readdata[WIDTH-1:0] = stable_q;
        2'd1: readdata = '0;
        2'd2: readdata[WIDTH-1:0] = irq_mask_q;
        2'd3: readdata[WIDTH-1:0] = edge_capture_q;
        default: readdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_pio_in_edge_irq.sv
// Bench for pio_in_edge_irq: three parameterizations against a cycle-level
// behavioural model, directed scenarios followed by random bus/pin traffic.
module tb_pio_in_edge_irq;

  localparam int NI = 3;
  localparam int unsigned M_ET [NI] = '{0, 2, 1};
  localparam int unsigned M_SS [NI] = '{2, 3, 2};
  localparam int unsigned M_N  [NI] = '{0, 8, 3};

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [3:0]  in_port;
  logic [31:0] rd [NI];
  logic        irq_w [NI];

  pio_in_edge_irq #(.WIDTH(4), .EDGE_TYPE(0), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(0)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(rd[0]), .irq(irq_w[0])
  );
  pio_in_edge_irq #(.WIDTH(4), .EDGE_TYPE(2), .SYNC_STAGES(3), .DEBOUNCE_CYCLES(8)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(rd[1]), .irq(irq_w[1])
  );
  pio_in_edge_irq #(.WIDTH(4), .EDGE_TYPE(1), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(3)) u_dut2 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(rd[2]), .irq(irq_w[2])
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Model state: pin sample history plus per-instance architectural registers.
  logic [3:0]  hist [$];
  logic [3:0]  m_stable [NI];
  logic [3:0]  m_prev [NI];
  logic [3:0]  m_cap [NI];
  logic [3:0]  m_mask [NI];
  logic        m_irq [NI];
  int          run [NI][4];
  logic [31:0] last_rd [NI];
  logic        last_irq [NI];
  logic [3:0]  p;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    for (int j = 0; j < 8; j++) hist.push_back(4'h0);
    for (int k = 0; k < NI; k++) begin
      m_stable[k] = '0; m_prev[k] = '0; m_cap[k] = '0; m_mask[k] = '0; m_irq[k] = 1'b0;
      for (int i = 0; i < 4; i++) run[k][i] = 0;
    end
  endtask

  // Advance the model across one rising edge using the currently driven inputs.
  task automatic model_edge();
    logic wr;
    wr = chipselect && !write_n;
    for (int k = 0; k < NI; k++) begin
      logic [3:0] sv, ns, ev;
      sv = hist[hist.size() - M_SS[k]];
      ns = m_stable[k];
      for (int i = 0; i < 4; i++) begin
        if (M_N[k] == 0) begin
          ns[i] = sv[i];
        end else if (sv[i] != m_stable[k][i]) begin
          run[k][i]++;
          if (run[k][i] == int'(M_N[k])) begin
            ns[i] = sv[i];
            run[k][i] = 0;
          end
        end else begin
          run[k][i] = 0;
        end
      end
      if (M_ET[k] == 0) ev = m_stable[k] & ~m_prev[k];
      else if (M_ET[k] == 1) ev = ~m_stable[k] & m_prev[k];
      else ev = m_stable[k] ^ m_prev[k];
      m_irq[k] = |(m_cap[k] & m_mask[k]);
      m_cap[k] = (m_cap[k] & ~((wr && address == 2'd3) ? writedata[3:0] : 4'h0)) | ev;
      if (wr && address == 2'd2) m_mask[k] = writedata[3:0];
      m_prev[k] = m_stable[k];
      m_stable[k] = ns;
    end
    hist.push_back(in_port);
    void'(hist.pop_front());
  endtask

  function automatic logic [31:0] exp_rd(input int k);
    if (!chipselect) return 32'h0;
    case (address)
      2'd0: return {28'h0, m_stable[k]};
      2'd2: return {28'h0, m_mask[k]};
      2'd3: return {28'h0, m_cap[k]};
      default: return 32'h0;
    endcase
  endfunction

  task automatic compare_all(input string pfx);
    for (int k = 0; k < NI; k++) begin
      check($sformatf("%s_rd%0d", pfx, k), rd[k], exp_rd(k));
      check($sformatf("%s_irq%0d", pfx, k), {31'h0, irq_w[k]}, {31'h0, m_irq[k]});
      last_rd[k]  = rd[k];
      last_irq[k] = irq_w[k];
    end
  endtask

  task automatic cycle(input logic [1:0] a, input logic c, input logic wn,
                       input logic [31:0] wd, input logic [3:0] pins);
    @(negedge clk);
    address = a; chipselect = c; write_n = wn; writedata = wd; in_port = pins;
    #1;
    compare_all("cyc");
    @(posedge clk);
    model_edge();
  endtask

  task automatic rd_cyc(input logic [1:0] a);
    cycle(a, 1'b1, 1'b1, 32'h0, p);
  endtask

  task automatic wr_cyc(input logic [1:0] a, input logic [31:0] d);
    cycle(a, 1'b1, 1'b0, d, p);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0; chipselect = 1'b1; write_n = 1'b1;
    address = 2'($urandom_range(0, 3)); in_port = p;
    model_reset();
    #1;
    compare_all("rst");
    @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  initial begin
    int first;
    reset_n = 1'b1; address = '0; chipselect = 1'b0; write_n = 1'b1;
    writedata = '0; p = 4'b1010; in_port = p;
    model_reset();

    // Reset readback with pins already high.
    do_reset();
    for (int j = 1; j <= 4; j++) rd_cyc(2'd0);
    check("rst_data", last_rd[0], 32'hA);
    rd_cyc(2'd1); check("rst_rsvd", last_rd[0], 32'h0);
    rd_cyc(2'd2); check("rst_mask", last_rd[0], 32'h0);
    check("rst_irq", {31'h0, last_irq[0]}, 32'h0);
    for (int j = 0; j < 20; j++) rd_cyc(2'd0);

    // Rising capture and irq timing.
    wr_cyc(2'd3, 32'hF);
    wr_cyc(2'd2, 32'h1);
    p = 4'b1011;
    for (int j = 1; j <= 6; j++) begin
      rd_cyc(2'd3);
      if (j == 4) check("rise_precap", last_rd[0], 32'h0);
      if (j == 5) begin
        check("rise_cap", last_rd[0], 32'h1);
        check("rise_irq_lag", {31'h0, last_irq[0]}, 32'h0);
      end
      if (j == 6) check("rise_irq", {31'h0, last_irq[0]}, 32'h1);
    end
    wr_cyc(2'd3, 32'h1);
    rd_cyc(2'd3);
    check("clr_cap", last_rd[0], 32'h0);
    check("clr_irq_lag", {31'h0, last_irq[0]}, 32'h1);
    rd_cyc(2'd3);
    check("clr_irq", {31'h0, last_irq[0]}, 32'h0);

    // Masked capture, then unmask.
    p = 4'b1111;
    for (int j = 0; j < 6; j++) rd_cyc(2'd3);
    check("mask_cap", last_rd[0], 32'h4);
    check("mask_noirq", {31'h0, last_irq[0]}, 32'h0);
    wr_cyc(2'd2, 32'h5);
    rd_cyc(2'd2);
    check("mask_rd", last_rd[0], 32'h5);
    rd_cyc(2'd3);
    check("mask_irq", {31'h0, last_irq[0]}, 32'h1);

    // Clear colliding with a new event on the same bit.
    wr_cyc(2'd2, 32'h2);
    p = 4'b1101;
    for (int j = 0; j < 5; j++) rd_cyc(2'd3);
    p = 4'b1111;
    rd_cyc(2'd3); rd_cyc(2'd3); rd_cyc(2'd3);
    wr_cyc(2'd3, 32'h2);
    rd_cyc(2'd3);
    check("coll_cap", {31'h0, last_rd[0][1]}, 32'h1);
    rd_cyc(2'd3);
    check("coll_irq", {31'h0, last_irq[0]}, 32'h1);

    // Debounce: short glitch rejected, long level accepted, falling edge seen.
    p = 4'b0111;
    for (int j = 0; j < 20; j++) rd_cyc(2'd0);
    wr_cyc(2'd3, 32'hF);
    p = 4'b1111;
    for (int j = 0; j < 5; j++) rd_cyc(2'd0);
    p = 4'b0111;
    for (int j = 0; j < 20; j++) rd_cyc(2'd0);
    rd_cyc(2'd3);
    check("glitch_nocap", last_rd[1], 32'h0);
    p = 4'b1111;
    first = 0;
    for (int j = 1; j <= 20; j++) begin
      rd_cyc(2'd0);
      if (first == 0 && last_rd[1][3]) first = j;
    end
    check("deb_latency", first, 32'd12);
    rd_cyc(2'd3);
    check("deb_rise_cap", last_rd[1], 32'h8);
    wr_cyc(2'd3, 32'hF);
    p = 4'b0111;
    for (int j = 0; j < 20; j++) rd_cyc(2'd0);
    rd_cyc(2'd3);
    check("deb_fall_cap", last_rd[1], 32'h8);

    // Reset in the middle of capture with irq asserted.
    p = 4'b0000;
    do_reset();
    for (int j = 0; j < 5; j++) rd_cyc(2'd0);
    p = 4'b1111;
    for (int j = 0; j < 6; j++) rd_cyc(2'd0);
    wr_cyc(2'd2, 32'hF);
    rd_cyc(2'd3);
    check("pre_rst_cap", last_rd[0], 32'hF);
    rd_cyc(2'd3);
    check("pre_rst_irq", {31'h0, last_irq[0]}, 32'h1);
    do_reset();
    check("in_rst_irq", {31'h0, last_irq[0]}, 32'h0);
    for (int j = 0; j < 6; j++) rd_cyc(2'd0);
    check("post_rst_data", last_rd[0], 32'hF);
    rd_cyc(2'd3);
    check("post_rst_cap", last_rd[0], 32'hF);

    // Random bus traffic and pin activity.
    for (int j = 0; j < 2000; j++) begin
      if ($urandom_range(0, 499) == 0) do_reset();
      if ($urandom_range(0, 7) == 0) p[$urandom_range(0, 3)] = ~p[$urandom_range(0, 3)];
      if ($urandom_range(0, 39) == 0) p = 4'($urandom);
      cycle(2'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 3) != 0), $urandom, p);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
